// File: rtl/accel_host_sequencer.sv
// Bus initiator: takes one (A, B, op) job, writes it to the accelerator, reads back the 16-bit result.
// Latency: res_valid 7 cycles after job acceptance (10 with ACCEL_HOST_VERIFY_EN readback of A/B/op).
// Backpressure: job_ready low while busy; result held in DONE until res_ready.
module accel_host_sequencer #(
   parameter logic [3:0] ADDR_A      = 4'h0,
   parameter logic [3:0] ADDR_B      = 4'h1,
   parameter logic [3:0] ADDR_OP     = 4'h4,
   parameter logic [3:0] ADDR_LATCH  = 4'hF,
   parameter logic [3:0] ADDR_RES_LO = 4'h5,
   parameter logic [3:0] ADDR_RES_HI = 4'h6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [7:0]  job_a,
   input  logic [7:0]  job_b,
   input  logic [3:0]  job_op,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        res_err,
   output logic [3:0]  bus_address,
   output logic        bus_write,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata
);

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
   } job_t;

   typedef enum logic [3:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_OP,
      WR_LATCH,
`ifdef ACCEL_HOST_VERIFY_EN
      RB_A,
      RB_B,
      RB_OP,
`endif
      RD_LO,
      RD_HI,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   job_t        job_q;
   logic [15:0] res_data_q;

   // Bus outputs depend only on state and the job latch, never on live inputs.
   always_comb begin
      state_nxt   = state;
      job_ready   = 1'b0;
      res_valid   = 1'b0;
      bus_write   = 1'b0;
      bus_address = 4'h0;
      bus_wdata   = 8'h00;
      case (state)
         IDLE: begin
            job_ready = 1'b1;
            if (job_valid) state_nxt = WR_A;
         end
         WR_A: begin
            bus_write   = 1'b1;
            bus_address = ADDR_A;
            bus_wdata   = job_q.a;
            state_nxt   = WR_B;
         end
         WR_B: begin
            bus_write   = 1'b1;
            bus_address = ADDR_B;
            bus_wdata   = job_q.b;
            state_nxt   = WR_OP;
         end
         WR_OP: begin
            bus_write   = 1'b1;
            bus_address = ADDR_OP;
            bus_wdata   = {4'b0000, job_q.op};
            state_nxt   = WR_LATCH;
         end
         WR_LATCH: begin
            // The peripheral samples its result on any write from the already-updated registers,
            // so this extra write is what commits the result for the opcode just written.
            bus_write   = 1'b1;
            bus_address = ADDR_LATCH;
            bus_wdata   = 8'h00;
`ifdef ACCEL_HOST_VERIFY_EN
            state_nxt   = RB_A;
`else
            state_nxt   = RD_LO;
`endif
         end
`ifdef ACCEL_HOST_VERIFY_EN
         RB_A: begin
            bus_address = ADDR_A;
            state_nxt   = RB_B;
         end
         RB_B: begin
            bus_address = ADDR_B;
            state_nxt   = RB_OP;
         end
         RB_OP: begin
            bus_address = ADDR_OP;
            state_nxt   = RD_LO;
         end
`endif
         RD_LO: begin
            bus_address = ADDR_RES_LO;
            state_nxt   = RD_HI;
         end
         RD_HI: begin
            bus_address = ADDR_RES_HI;
            state_nxt   = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         job_q      <= '0;
         res_data_q <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (state == IDLE && job_valid) begin
            job_q.a  <= job_a;
            job_q.b  <= job_b;
            job_q.op <= job_op;
         end
         if (state == RD_LO) res_data_q[7:0]  <= bus_rdata;
         if (state == RD_HI) res_data_q[15:8] <= bus_rdata;
      end
   end

   assign res_data = res_data_q;

`ifdef ACCEL_HOST_VERIFY_EN
   logic res_err_q;

   // Sticky for the job; cleared only when the next job is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_err_q <= 1'b0;
      end else if (state == IDLE && job_valid) begin
         res_err_q <= 1'b0;
      end else if ((state == RB_A  && bus_rdata != job_q.a) ||
                   (state == RB_B  && bus_rdata != job_q.b) ||
                   (state == RB_OP && bus_rdata != {4'b0000, job_q.op})) begin
         res_err_q <= 1'b1;
      end
   end

   assign res_err = res_err_q;
`else
   assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_accel_host_sequencer.sv
// Directed bench: sequencer driving a small accelerator peripheral model (add/sub/mul, result on any write).
module tb_accel_host_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid;
   logic        job_ready;
   logic [7:0]  job_a;
   logic [7:0]  job_b;
   logic [3:0]  job_op;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_err;
   logic [3:0]  bus_address;
   logic        bus_write;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;

   int errs   = 0;
   int checks = 0;

`ifdef ACCEL_HOST_VERIFY_EN
   localparam int RB_CYCLES = 3;
`else
   localparam int RB_CYCLES = 0;
`endif

   always #5 clk = ~clk;

   accel_host_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .job_a       (job_a),
      .job_b       (job_b),
      .job_op      (job_op),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_err     (res_err),
      .bus_address (bus_address),
      .bus_write   (bus_write),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata)
   );

   // Peripheral model: result register captured on any write from the registers as they stood before it.
   logic [7:0]  pa = 8'h00;
   logic [7:0]  pb = 8'h00;
   logic [3:0]  pop = 4'h0;
   logic [15:0] pres = 16'h0000;
   logic        corrupt_b = 1'b0;

   function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      case (op)
         4'd0:    return {8'h00, a} + {8'h00, b};
         4'd1:    return {8'h00, a} - {8'h00, b};
         4'd2:    return {8'h00, a} * {8'h00, b};
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus_write) begin
         pres <= alu(pa, pb, pop);
         case (bus_address)
            4'h0: pa  <= bus_wdata;
            4'h1: pb  <= bus_wdata;
            4'h4: pop <= bus_wdata[3:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      bus_rdata = 8'h00;
      case (bus_address)
         4'h0: bus_rdata = pa;
         4'h1: bus_rdata = pb ^ (corrupt_b ? 8'h01 : 8'h00);
         4'h4: bus_rdata = {4'h0, pop};
         4'h5: bus_rdata = pres[7:0];
         4'h6: bus_rdata = pres[15:8];
         default: bus_rdata = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers a job, checks every bus cycle, the result in DONE, an optional stall, then release.
   task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input logic [15:0] exp, input logic exp_err, input int hold);
      logic [3:0] wa [4];
      logic [7:0] wd [4];
      logic [3:0] ra [3];
      wa[0] = 4'h0; wa[1] = 4'h1; wa[2] = 4'h4; wa[3] = 4'hF;
      wd[0] = a;    wd[1] = b;    wd[2] = {4'h0, op}; wd[3] = 8'h00;
      ra[0] = 4'h0; ra[1] = 4'h1; ra[2] = 4'h4;
      check("idle_job_ready", job_ready, 1);
      job_valid = 1'b1; job_a = a; job_b = b; job_op = op;
      tick();
      // Inputs change after acceptance and must have no effect.
      job_valid = 1'b0; job_a = ~a; job_b = ~b; job_op = ~op;
      for (int k = 0; k < 4; k++) begin
         check("wr_write", bus_write, 1);
         check("wr_addr", bus_address, wa[k]);
         check("wr_data", bus_wdata, wd[k]);
         check("busy_job_ready", job_ready, 0);
         tick();
      end
      for (int k = 0; k < RB_CYCLES; k++) begin
         check("rb_write", bus_write, 0);
         check("rb_addr", bus_address, ra[k]);
         tick();
      end
      check("rd_lo_addr", bus_address, 4'h5);
      check("rd_lo_write", bus_write, 0);
      check("rd_lo_valid", res_valid, 0);
      tick();
      check("rd_hi_addr", bus_address, 4'h6);
      check("rd_hi_write", bus_write, 0);
      check("rd_hi_valid", res_valid, 0);
      tick();
      check("done_valid", res_valid, 1);
      check("done_data", res_data, exp);
      check("done_err", res_err, exp_err);
      check("done_job_ready", job_ready, 0);
      check("done_bus_write", bus_write, 0);
      job_valid = (hold > 0); job_a = 8'h11; job_b = 8'h22; job_op = 4'h2;
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", res_valid, 1);
         check("hold_data", res_data, exp);
         check("hold_job_ready", job_ready, 0);
         check("hold_bus_write", bus_write, 0);
      end
      job_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("release_valid", res_valid, 0);
      check("release_job_ready", job_ready, 1);
      check("release_bus_write", bus_write, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
      job_a = 8'h00; job_b = 8'h00; job_op = 4'h0;
      tick();
      tick();
      check("rst_job_ready", job_ready, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 16'h0000);
      check("rst_res_err", res_err, 0);
      check("rst_bus_write", bus_write, 0);
      check("rst_bus_address", bus_address, 4'h0);
      check("rst_bus_wdata", bus_wdata, 8'h00);
      rst_n = 1'b1;
      tick();

      run_job(8'd200, 8'd100, 4'd0, 16'h012C, 1'b0, 0);   // ADD
      run_job(8'd5,   8'd7,   4'd1, 16'hFFFE, 1'b0, 0);   // SUB wraps
      run_job(8'd255, 8'd255, 4'd2, 16'hFE01, 1'b0, 0);   // MUL max
      run_job(8'd9,   8'd3,   4'd7, 16'h0000, 1'b0, 0);   // unsupported op
      run_job(8'd40,  8'd2,   4'd0, 16'h002A, 1'b0, 10);  // backpressure, job_valid ignored

      // Reset during WR_B.
      job_valid = 1'b1; job_a = 8'd1; job_b = 8'd2; job_op = 4'd0;
      tick();
      job_valid = 1'b0;
      tick();
      check("mid_in_wr_b_addr", bus_address, 4'h1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_bus_write", bus_write, 0);
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_job_ready", job_ready, 1);
      check("mid_rst_bus_addr", bus_address, 4'h0);
      rst_n = 1'b1;
      tick();
      run_job(8'd16, 8'd16, 4'd2, 16'h0100, 1'b0, 0);

`ifdef ACCEL_HOST_VERIFY_EN
      corrupt_b = 1'b1;
      run_job(8'd10, 8'd20, 4'd0, 16'h001E, 1'b1, 0);
      corrupt_b = 1'b0;
      run_job(8'd3, 8'd4, 4'd2, 16'h000C, 1'b0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
